// File: rtl/emotion_pkg.sv
// Shared types for the emotion decision path: label encoding, class count
// and the vote state machine encoding.
package emotion_pkg;

    typedef logic [1:0] label_t;

    localparam label_t LABEL_NONE  = 2'd3;
    localparam int     NUM_CLASSES = 3;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        TRACKING
    } vote_state_t;

endpackage

// File: rtl/argmax3.sv
// Combinational three-way argmax with top-1/top-2 margin. Ties resolve to the
// lower index; the margin is formed at 17 bits so a full-scale spread fits.
module argmax3
    import emotion_pkg::*;
(
    input  logic signed [15:0] y0,
    input  logic signed [15:0] y1,
    input  logic signed [15:0] y2,
    output label_t             top,
    output logic        [16:0] margin
);

    logic signed [15:0] top_val;
    logic signed [15:0] sec_val;
    logic signed [16:0] diff;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        top     = 2'd0;
        top_val = y0;
        sec_val = (y1 > y2) ? y1 : y2;
        // NOTE: blocking assignments in combinational logic, so later
        // comparisons see the updated top_val within the same evaluation.
        if (y1 > top_val) begin
            top     = 2'd1;
            top_val = y1;
            sec_val = (y0 > y2) ? y0 : y2;
        end
        if (y2 > top_val) begin
            top     = 2'd2;
            top_val = y2;
            sec_val = (y0 > y1) ? y0 : y1;
        end
    end

    assign diff   = {top_val[15], top_val} - {sec_val[15], sec_val};
    assign margin = diff;

endmodule

// File: rtl/emotion_vote_filter.sv
// Turns per-frame class scores into a stable label: registered argmax, margin
// gate, sliding-window class histogram and a hysteretic majority vote.
module emotion_vote_filter
    import emotion_pkg::*;
#(
    parameter int WIN        = 8,
    parameter int MARGIN_MIN = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         valid_in,
    input  logic signed [15:0]           y0,
    input  logic signed [15:0]           y1,
    input  logic signed [15:0]           y2,
    output logic                         label_valid,
    output logic [1:0]                   label,
    output logic [$clog2(WIN+1)-1:0]     conf,
    output logic                         changed
);

    localparam int CW = $clog2(WIN + 1);
    localparam int PW = $clog2(WIN);
    localparam logic [CW-1:0] FILL_FULL = CW'(WIN);
    localparam logic [CW-1:0] FILL_HALF = CW'(WIN / 2);
    localparam logic [PW-1:0] PTR_LAST  = PW'(WIN - 1);

    typedef logic [NUM_CLASSES-1:0][CW-1:0] counts_t;

    function automatic logic [CW-1:0] count_of(input counts_t c, input label_t l);
        case (l)
            2'd0:    return c[0];
            2'd1:    return c[1];
            2'd2:    return c[2];
            default: return '0;
        endcase
    endfunction

    // ---------------- stage 1: argmax ----------------
    label_t      a_top;
    logic [16:0] a_margin;

    argmax3 u_argmax (
        .y0     (y0),
        .y1     (y1),
        .y2     (y2),
        .top    (a_top),
        .margin (a_margin)
    );

    logic        s1_valid;
    label_t      s1_class;
    logic [16:0] s1_margin;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) s1_valid <= 1'b0;
        else                s1_valid <= valid_in;
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            s1_class  <= a_top;
            s1_margin <= a_margin;
        end
    end

    // ---------------- stage 2: history ----------------
    logic            accept;
    logic [1:0]      hist [WIN];
    logic [PW-1:0]   ptr,  ptr_nxt;
    logic [CW-1:0]   fill, fill_nxt;
    counts_t         cnt,  cnt_nxt;
    label_t          evicted;
    logic            evict_en;

    assign accept   = s1_valid && (s1_margin >= 17'(MARGIN_MIN));
    assign evicted  = hist[ptr];
    assign evict_en = accept && (fill == FILL_FULL);

    always_comb begin
        cnt_nxt  = cnt;
        fill_nxt = fill;
        ptr_nxt  = ptr;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (evict_en && evicted == label_t'(c))
                cnt_nxt[c] = cnt_nxt[c] - CW'(1);
            if (accept && s1_class == label_t'(c))
                cnt_nxt[c] = cnt_nxt[c] + CW'(1);
        end
        if (accept) begin
            ptr_nxt = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
            if (fill != FILL_FULL) fill_nxt = fill + CW'(1);
        end
    end

    // NOTE: the history array has no reset; entries are only read once fill
    // proves they were written, so clearing fill is enough.
    always_ff @(posedge clk) begin
        if (accept) hist[ptr] <= s1_class;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr  <= '0;
            fill <= '0;
            cnt  <= '0;
        end else begin
            ptr  <= ptr_nxt;
            fill <= fill_nxt;
            cnt  <= cnt_nxt;
        end
    end

    // ---------------- vote ----------------
    label_t cand;

    always_comb begin
        cand = 2'd0;
        if (cnt_nxt[1] > cnt_nxt[0])    cand = 2'd1;
        if (cnt_nxt[2] > cnt_nxt[cand]) cand = 2'd2;
    end

    vote_state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (reset || clear) state <= EMPTY;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:    if (accept) state_nxt = FILLING;
            FILLING:  if (fill_nxt >= FILL_HALF) state_nxt = TRACKING;
            TRACKING: state_nxt = TRACKING;
            default:  state_nxt = EMPTY;
        endcase
    end

    label_t        label_nxt;
    logic [CW-1:0] conf_nxt;
    logic          changed_nxt;

    // Once tracking, the label moves only when the candidate strictly out-votes it.
    always_comb begin
        label_nxt = label;
        if (state == FILLING && state_nxt == TRACKING)
            label_nxt = cand;
        else if (state == TRACKING && count_of(cnt_nxt, cand) > count_of(cnt_nxt, label))
            label_nxt = cand;
        conf_nxt    = count_of(cnt_nxt, label_nxt);
        changed_nxt = s1_valid && (label_nxt != label);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            label_valid <= 1'b0;
            label       <= LABEL_NONE;
            conf        <= '0;
            changed     <= 1'b0;
        end else begin
            label_valid <= s1_valid;
            changed     <= changed_nxt;
            if (s1_valid) begin
                label <= label_nxt;
                conf  <= conf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_emotion_vote_filter.sv
// Directed bench for emotion_vote_filter with WIN=8, MARGIN_MIN=64: fill-up,
// margin gate, extreme scores, hysteresis and clear/reset collisions.
module tb_emotion_vote_filter;
    import emotion_pkg::*;

    localparam int WIN        = 8;
    localparam int MARGIN_MIN = 64;
    localparam int CW         = $clog2(WIN + 1);

    typedef struct {
        logic [1:0]    label;
        logic [CW-1:0] conf;
        logic          changed;
        int            cyc;
    } pulse_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 clear = 1'b0;
    logic                 valid_in = 1'b0;
    logic signed [15:0]   y0 = '0;
    logic signed [15:0]   y1 = '0;
    logic signed [15:0]   y2 = '0;
    logic                 label_valid;
    logic [1:0]           label;
    logic [CW-1:0]        conf;
    logic                 changed;

    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     stray_changed = 0;
    pulse_t pq[$];
    int     fq[$];

    emotion_vote_filter #(.WIN(WIN), .MARGIN_MIN(MARGIN_MIN)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .valid_in    (valid_in),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .label_valid (label_valid),
        .label       (label),
        .conf        (conf),
        .changed     (changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (label_valid === 1'b1) pq.push_back('{label, conf, changed, cyc});
        if (changed === 1'b1 && label_valid !== 1'b1) stray_changed++;
    end

    task automatic frame(input int a, input int b, input int c, input bit with_clear = 1'b0);
        @(posedge clk); #1;
        valid_in = 1'b1;
        clear    = with_clear;
        y0 = 16'(a); y1 = 16'(b); y2 = 16'(c);
        if (!with_clear) fq.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            clear    = 1'b0;
        end
    endtask

    task automatic flush_history();
        @(posedge clk); #1;
        valid_in = 1'b0;
        clear    = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_checks++;
        if (label !== 2'd3 || conf !== '0 || changed !== 1'b0 || label_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_outputs: got label=%0d conf=%0d changed=%0d valid=%0d, want 3 0 0 0",
                     label, conf, changed, label_valid);
        end
        idle(2);
        pq.delete();
        fq.delete();
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (label !== 2'd3 || conf !== '0 || label_valid !== 1'b0 || changed !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: got label=%0d conf=%0d valid=%0d changed=%0d, want 3 0 0 0",
                         label, conf, label_valid, changed);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (label !== 2'd3 || conf !== '0 || label_valid !== 1'b0 || changed !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: got label=%0d conf=%0d valid=%0d changed=%0d, want 3 0 0 0",
                         label, conf, label_valid, changed);
            end
        end
        pq.delete();
        fq.delete();
    endtask

    task automatic test_fill_up();
        int el[$] = '{3, 3, 3, 0};
        int ec[$] = '{0, 0, 0, 4};
        int eg[$] = '{0, 0, 0, 1};
        repeat (4) frame(100, -50, 20);
        idle(4);
        n_checks++;
        if (pq.size() != el.size()) begin
            n_fail++;
            $display("FAIL fill_up count: got %0d pulses, want %0d", pq.size(), el.size());
        end
        for (int i = 0; i < el.size() && i < pq.size() && i < fq.size(); i++) begin
            n_checks++;
            if (pq[i].label !== 2'(el[i]) || pq[i].conf !== CW'(ec[i]) ||
                pq[i].changed !== 1'(eg[i]) || pq[i].cyc != fq[i] + 2) begin
                n_fail++;
                $display("FAIL fill_up pulse %0d: got label=%0d conf=%0d changed=%0d cyc=%0d, want %0d %0d %0d cyc=%0d",
                         i, pq[i].label, pq[i].conf, pq[i].changed, pq[i].cyc, el[i], ec[i], eg[i], fq[i] + 2);
            end
        end
    endtask

    task automatic test_low_margin();
        int el[$] = '{3, 3, 3, 3, 0};
        int ec[$] = '{0, 0, 0, 0, 4};
        int eg[$] = '{0, 0, 0, 0, 1};
        flush_history();
        frame(100, 90, -5);
        repeat (4) frame(100, -50, 20);
        idle(4);
        n_checks++;
        if (pq.size() != el.size()) begin
            n_fail++;
            $display("FAIL low_margin count: got %0d pulses, want %0d", pq.size(), el.size());
        end
        for (int i = 0; i < el.size() && i < pq.size() && i < fq.size(); i++) begin
            n_checks++;
            if (pq[i].label !== 2'(el[i]) || pq[i].conf !== CW'(ec[i]) ||
                pq[i].changed !== 1'(eg[i]) || pq[i].cyc != fq[i] + 2) begin
                n_fail++;
                $display("FAIL low_margin pulse %0d: got label=%0d conf=%0d changed=%0d cyc=%0d, want %0d %0d %0d cyc=%0d",
                         i, pq[i].label, pq[i].conf, pq[i].changed, pq[i].cyc, el[i], ec[i], eg[i], fq[i] + 2);
            end
        end
    endtask

    task automatic test_extreme_scores();
        int el[$] = '{3, 3, 3, 0, 0, 0, 0, 0};
        int ec[$] = '{0, 0, 0, 4, 4, 4, 5, 5};
        int eg[$] = '{0, 0, 0, 1, 0, 0, 0, 0};
        flush_history();
        repeat (4) frame(32767, -32768, -32768);
        frame(200, 200, 0);
        frame(-32768, -32768, 32767);
        frame(64, 0, 0);
        frame(63, 0, 0);
        idle(4);
        n_checks++;
        if (pq.size() != el.size()) begin
            n_fail++;
            $display("FAIL extreme count: got %0d pulses, want %0d", pq.size(), el.size());
        end
        for (int i = 0; i < el.size() && i < pq.size() && i < fq.size(); i++) begin
            n_checks++;
            if (pq[i].label !== 2'(el[i]) || pq[i].conf !== CW'(ec[i]) ||
                pq[i].changed !== 1'(eg[i]) || pq[i].cyc != fq[i] + 2) begin
                n_fail++;
                $display("FAIL extreme pulse %0d: got label=%0d conf=%0d changed=%0d cyc=%0d, want %0d %0d %0d cyc=%0d",
                         i, pq[i].label, pq[i].conf, pq[i].changed, pq[i].cyc, el[i], ec[i], eg[i], fq[i] + 2);
            end
        end
    endtask

    task automatic test_back_to_back_hysteresis();
        int el[$] = '{3, 3, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
        int ec[$] = '{0, 0, 0, 4, 5, 6, 7, 8,  7, 6, 5, 4, 5};
        int eg[$] = '{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1};
        flush_history();
        repeat (8) frame(100, -50, 20);
        repeat (5) frame(-50, 100, 20);
        idle(4);
        n_checks++;
        if (pq.size() != el.size()) begin
            n_fail++;
            $display("FAIL hysteresis count: got %0d pulses, want %0d", pq.size(), el.size());
        end
        for (int i = 0; i < el.size() && i < pq.size() && i < fq.size(); i++) begin
            n_checks++;
            if (pq[i].label !== 2'(el[i]) || pq[i].conf !== CW'(ec[i]) ||
                pq[i].changed !== 1'(eg[i]) || pq[i].cyc != fq[i] + 2) begin
                n_fail++;
                $display("FAIL hysteresis pulse %0d: got label=%0d conf=%0d changed=%0d cyc=%0d, want %0d %0d %0d cyc=%0d",
                         i, pq[i].label, pq[i].conf, pq[i].changed, pq[i].cyc, el[i], ec[i], eg[i], fq[i] + 2);
            end
        end
    endtask

    task automatic test_clear_collision();
        int el[$] = '{3, 3, 3, 0};
        int ec[$] = '{0, 0, 0, 4};
        int eg[$] = '{0, 0, 0, 1};
        flush_history();
        frame(100, -50, 20, 1'b1);
        repeat (3) frame(100, -50, 20);
        idle(1);
        frame(100, -50, 20);
        idle(4);
        n_checks++;
        if (pq.size() != el.size()) begin
            n_fail++;
            $display("FAIL clear_collision count: got %0d pulses, want %0d", pq.size(), el.size());
        end
        for (int i = 0; i < el.size() && i < pq.size() && i < fq.size(); i++) begin
            n_checks++;
            if (pq[i].label !== 2'(el[i]) || pq[i].conf !== CW'(ec[i]) ||
                pq[i].changed !== 1'(eg[i]) || pq[i].cyc != fq[i] + 2) begin
                n_fail++;
                $display("FAIL clear_collision pulse %0d: got label=%0d conf=%0d changed=%0d cyc=%0d, want %0d %0d %0d cyc=%0d",
                         i, pq[i].label, pq[i].conf, pq[i].changed, pq[i].cyc, el[i], ec[i], eg[i], fq[i] + 2);
            end
        end
    endtask

    task automatic test_clear_in_flight();
        pq.delete();
        fq.delete();
        frame(-50, 100, 20);
        @(posedge clk); #1;
        valid_in = 1'b0;
        clear    = 1'b1;
        idle(4);
        n_checks++;
        if (pq.size() != 0 || label !== 2'd3 || conf !== '0) begin
            n_fail++;
            $display("FAIL clear_in_flight: got %0d pulses label=%0d conf=%0d, want 0 pulses label=3 conf=0",
                     pq.size(), label, conf);
        end
    endtask

    task automatic test_reset_in_flight();
        int el[$] = '{3, 3, 3, 0};
        int ec[$] = '{0, 0, 0, 4};
        int eg[$] = '{0, 0, 0, 1};
        repeat (4) frame(-50, 100, 20);
        idle(4);
        n_checks++;
        if (label !== 2'd1 || conf !== CW'(4)) begin
            n_fail++;
            $display("FAIL reset_prep: got label=%0d conf=%0d, want label=1 conf=4", label, conf);
        end
        pq.delete();
        fq.delete();
        frame(100, -50, 20);
        @(posedge clk); #1;
        valid_in = 1'b1;
        reset    = 1'b1;
        y0 = 16'(-50); y1 = 16'(100); y2 = 16'(20);
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(4);
        n_checks++;
        if (pq.size() != 0 || label !== 2'd3 || conf !== '0) begin
            n_fail++;
            $display("FAIL reset_in_flight: got %0d pulses label=%0d conf=%0d, want 0 pulses label=3 conf=0",
                     pq.size(), label, conf);
        end
        pq.delete();
        fq.delete();
        repeat (4) frame(100, -50, 20);
        idle(4);
        n_checks++;
        if (pq.size() != el.size()) begin
            n_fail++;
            $display("FAIL after_reset count: got %0d pulses, want %0d", pq.size(), el.size());
        end
        for (int i = 0; i < el.size() && i < pq.size() && i < fq.size(); i++) begin
            n_checks++;
            if (pq[i].label !== 2'(el[i]) || pq[i].conf !== CW'(ec[i]) ||
                pq[i].changed !== 1'(eg[i]) || pq[i].cyc != fq[i] + 2) begin
                n_fail++;
                $display("FAIL after_reset pulse %0d: got label=%0d conf=%0d changed=%0d cyc=%0d, want %0d %0d %0d cyc=%0d",
                         i, pq[i].label, pq[i].conf, pq[i].changed, pq[i].cyc, el[i], ec[i], eg[i], fq[i] + 2);
            end
        end
    endtask

    task automatic test_changed_only_with_pulse();
        n_checks++;
        if (stray_changed != 0) begin
            n_fail++;
            $display("FAIL changed_outside_pulse: got %0d stray cycles, want 0", stray_changed);
        end
    endtask

    initial begin
        test_reset();
        test_fill_up();
        test_low_margin();
        test_extreme_scores();
        test_back_to_back_hysteresis();
        test_clear_collision();
        test_clear_in_flight();
        test_reset_in_flight();
        test_changed_only_with_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
